// File: rtl/sprite_motion_pkg.sv
// Shared display definitions: FSM encoding, position type, screen defaults
// and the per-axis step/clamp rule used by the sprite mover.
package sprite_motion_pkg;

    localparam int SCREEN_W_DEFAULT = 800;
    localparam int SCREEN_H_DEFAULT = 480;

    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef enum logic [1:0] {
        IDLE,
        STEP_X,
        STEP_Y,
        PUBLISH
    } motion_state_t;

    typedef logic signed [15:0] pos_t;

    typedef struct packed {
        pos_t pos;
        logic dir;
        logic bounce;
    } axis_step_t;

    // 17-bit arithmetic so a step past either wall is seen before it can wrap.
    function automatic axis_step_t step_axis(input pos_t pos, input logic dir,
                                             input logic [3:0] speed, input pos_t max_pos);
        logic signed [16:0] cur;
        logic signed [16:0] delta;
        logic signed [16:0] lim;
        logic signed [16:0] nxt;
        axis_step_t res;
        cur = {pos[15], pos};
        delta = {13'd0, speed};
        lim = {max_pos[15], max_pos};
        nxt = (dir == DIR_NEG) ? cur - delta : cur + delta;
        res.pos = pos;
        res.dir = dir;
        res.bounce = 1'b0;
        if (nxt <= 17'sd0) begin
            res.pos = '0;
            res.dir = DIR_POS;
            res.bounce = (dir == DIR_NEG);
        end else if (nxt >= lim) begin
            res.pos = max_pos;
            res.dir = DIR_NEG;
            res.bounce = (dir == DIR_POS);
        end else begin
            res.pos = nxt[15:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/sprite_motion_pulse_sync.sv
// Two-flop synchronizer plus rising-edge detector producing a one-cycle
// pulse in the clk domain from a level/pulse in another clock domain.
module pulse_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic pulse
);

    logic sync1;
    logic sync2;
    logic prev;
    logic [1:0] valid;

    // prev is held high until sync2 carries real samples, so a level already
    // high at reset release is not mistaken for a fresh edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b1;
            valid <= 2'b00;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            valid <= {valid[0], 1'b1};
            prev  <= valid[1] ? sync2 : 1'b1;
        end
    end

    assign pulse = valid[1] & sync2 & ~prev;

endmodule

// File: rtl/sprite_motion.sv
// Bouncing sprite position generator: one step per display frame, with both
// offsets published together so the display never sees a half-updated pair.
module sprite_motion
    import sprite_motion_pkg::*;
#(
    parameter int SCREEN_W  = SCREEN_W_DEFAULT,
    parameter int SCREEN_H  = SCREEN_H_DEFAULT,
    parameter int SPRITE_SZ = 64,
    parameter int INIT_X    = 123,
    parameter int INIT_Y    = 234
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        frame_int,
    input  logic [3:0]  speed_x,
    input  logic [3:0]  speed_y,
    input  logic        pause,
    output logic [15:0] offset_x,
    output logic [15:0] offset_y,
    output logic        update,
    output logic        bounce_x,
    output logic        bounce_y,
    output logic        corner,
    output logic        overrun
);

    localparam pos_t MAX_X  = pos_t'(SCREEN_W - SPRITE_SZ);
    localparam pos_t MAX_Y  = pos_t'(SCREEN_H - SPRITE_SZ);
    localparam pos_t START_X = pos_t'(INIT_X);
    localparam pos_t START_Y = pos_t'(INIT_Y);

    logic tick;
    motion_state_t state;
    pos_t x;
    pos_t y;
    logic dir_x;
    logic dir_y;
    logic [3:0] sx;
    logic [3:0] sy;
    logic bx_pend;
    logic by_pend;
    axis_step_t next_x;
    axis_step_t next_y;

    pulse_sync u_frame_sync (
        .clk      (clk),
        .reset    (reset),
        .async_in (frame_int),
        .pulse    (tick)
    );

    always_comb begin
        next_x = step_axis(x, dir_x, sx, MAX_X);
        next_y = step_axis(y, dir_y, sy, MAX_Y);
    end

    // x/y are working copies; offsets only follow them in PUBLISH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            x        <= START_X;
            y        <= START_Y;
            dir_x    <= DIR_POS;
            dir_y    <= DIR_POS;
            sx       <= '0;
            sy       <= '0;
            bx_pend  <= 1'b0;
            by_pend  <= 1'b0;
            offset_x <= START_X;
            offset_y <= START_Y;
            update   <= 1'b0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            corner   <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            update   <= 1'b0;
            bounce_x <= 1'b0;
            bounce_y <= 1'b0;
            corner   <= 1'b0;
            if (tick && state != IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (tick) begin
                        sx <= speed_x;
                        sy <= speed_y;
                        if (!pause) begin
                            state <= STEP_X;
                        end
                    end
                end
                STEP_X: begin
                    x       <= next_x.pos;
                    dir_x   <= next_x.dir;
                    bx_pend <= next_x.bounce;
                    state   <= STEP_Y;
                end
                STEP_Y: begin
                    y       <= next_y.pos;
                    dir_y   <= next_y.dir;
                    by_pend <= next_y.bounce;
                    state   <= PUBLISH;
                end
                PUBLISH: begin
                    offset_x <= x;
                    offset_y <= y;
                    update   <= 1'b1;
                    bounce_x <= bx_pend;
                    bounce_y <= by_pend;
                    corner   <= bx_pend & by_pend;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
